// File: rtl/apb_vector_alu_pkg.sv
// apb_vector_alu_pkg: op codes, register map, control/status bits and FSM states
package apb_vector_alu_pkg;
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DOT = 2'd3} op_t;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam logic [11:0] CTRL_OFF   = 12'h000;
    localparam logic [11:0] STATUS_OFF = 12'h004;
    localparam logic [11:0] ACC_OFF    = 12'h008;
    localparam logic [11:0] X_BASE     = 12'h100;
    localparam logic [11:0] Y_BASE     = 12'h200;
    localparam logic [11:0] Z_BASE     = 12'h300;
    localparam int CTRL_START = 2;
    localparam int CTRL_CLR   = 3;
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_OVF     = 2;
endpackage

// File: rtl/vector_alu_lane_unit.sv
// vector_alu_lane_unit: single-lane combinational ADD/SUB/MUL/DOT datapath with overflow
module vector_alu_lane_unit
    import apb_vector_alu_pkg::*;
#(
    parameter int BW_DATA = 32
) (
    input  op_t                op,
    input  logic [BW_DATA-1:0] x,
    input  logic [BW_DATA-1:0] y,
    input  logic [BW_DATA-1:0] acc,
    output logic [BW_DATA-1:0] result,
    output logic               overflow
);
    logic [BW_DATA:0]     sum;
    logic [BW_DATA:0]     diff;
    logic [BW_DATA:0]     mac;
    logic [2*BW_DATA-1:0] prod;
    always_comb begin
        sum  = {1'b0, x} + {1'b0, y};
        // the extra top bit of the difference is the borrow
        diff = {1'b0, x} - {1'b0, y};
        prod = {{BW_DATA{1'b0}}, x} * {{BW_DATA{1'b0}}, y};
        mac  = {1'b0, acc} + {1'b0, prod[BW_DATA-1:0]};
        result = op == OP_ADD ? sum[BW_DATA-1:0] :
                 op == OP_SUB ? diff[BW_DATA-1:0] :
                 op == OP_MUL ? prod[BW_DATA-1:0] : mac[BW_DATA-1:0];
        overflow = op == OP_ADD ? sum[BW_DATA] :
                   op == OP_SUB ? diff[BW_DATA] :
                   op == OP_MUL ? |prod[2*BW_DATA-1:BW_DATA] : mac[BW_DATA];
    end
endmodule

// File: rtl/apb_vector_alu.sv
// apb_vector_alu: APB slave running lane-sequential vector ADD/SUB/MUL/DOT over X/Y into Z/ACC
module apb_vector_alu
    import apb_vector_alu_pkg::*;
#(
    parameter  int BW_ADDR     = 12,
    parameter  int BW_DATA     = 32,
    parameter  int NUM_LANE    = 8,
    localparam int BW_LANE_IDX = NUM_LANE > 1 ? $clog2(NUM_LANE) : 1
) (
    input  logic               clk,
    input  logic               rstp,
    input  logic               rpsel,
    input  logic               rpenable,
    input  logic [BW_ADDR-1:0] rpaddr,
    input  logic               rpwrite,
    input  logic [BW_DATA-1:0] rpwdata,
    output logic [BW_DATA-1:0] rprdata,
    output logic               rpready,
    output logic               rpslverr
);
    logic [BW_DATA-1:0]     x_q [NUM_LANE];
    logic [BW_DATA-1:0]     y_q [NUM_LANE];
    logic [BW_DATA-1:0]     z_q [NUM_LANE];
    logic [BW_DATA-1:0]     acc_q;
    state_t                 state_q;
    state_t                 state_d;
    op_t                    op_q;
    logic [BW_LANE_IDX-1:0] idx_q;
    logic                   done_q;
    logic                   ovf_q;
    logic [11:0]            a;
    logic [BW_LANE_IDX-1:0] lane;
    logic                   access;
    logic                   hi_ok;
    logic                   lane_ok;
    logic                   is_ctrl;
    logic                   is_stat;
    logic                   is_acc;
    logic                   is_x;
    logic                   is_y;
    logic                   is_z;
    logic                   valid;
    logic                   busy;
    logic                   err;
    logic                   wr;
    logic                   start;
    logic                   clear;
    logic                   last;
    logic [BW_DATA-1:0]     res;
    logic                   lane_ovf;
    logic [BW_DATA-1:0]     rd_val;

    assign a       = rpaddr[11:0];
    assign access  = rpsel && rpenable;
    assign hi_ok   = (rpaddr >> 12) == '0;
    assign lane    = a[2 +: BW_LANE_IDX];
    assign lane_ok = a[1:0] == 2'b00 && {1'b0, a[7:2]} < 7'(NUM_LANE);
    assign is_ctrl = a == CTRL_OFF;
    assign is_stat = a == STATUS_OFF;
    assign is_acc  = a == ACC_OFF;
    assign is_x    = lane_ok && a[11:8] == X_BASE[11:8];
    assign is_y    = lane_ok && a[11:8] == Y_BASE[11:8];
    assign is_z    = lane_ok && a[11:8] == Z_BASE[11:8];
    assign valid   = hi_ok && (is_ctrl || is_stat || is_acc || is_x || is_y || is_z);
    assign busy    = state_q == RUN;
    // data registers are owned by the sequencer while it runs
    assign rpready  = !(access && valid && (is_acc || is_x || is_y || is_z) && busy);
    assign err      = access && (!valid || (is_ctrl && rpwrite && rpwdata[CTRL_START] && busy));
    assign rpslverr = err;
    assign wr       = access && rpready && rpwrite && !err;
    assign start    = wr && is_ctrl && rpwdata[CTRL_START];
    assign clear    = wr && is_ctrl && rpwdata[CTRL_CLR] && !busy;
    assign last     = idx_q == BW_LANE_IDX'(NUM_LANE - 1);
    assign rd_val = is_stat ? {{(BW_DATA-3){1'b0}}, ovf_q, done_q, busy} :
                    is_acc  ? acc_q :
                    is_x    ? x_q[lane] :
                    is_y    ? y_q[lane] :
                    is_z    ? z_q[lane] : '0;
    assign rprdata = access && valid && !rpwrite ? rd_val : '0;

    vector_alu_lane_unit #(.BW_DATA(BW_DATA)) u_lane (
        .op       (op_q),
        .x        (x_q[idx_q]),
        .y        (y_q[idx_q]),
        .acc      (acc_q),
        .result   (res),
        .overflow (lane_ovf)
    );

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            op_q   <= OP_ADD;
            idx_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (start) begin
            op_q   <= op_t'(rpwdata[1:0]);
            idx_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (busy) begin
            idx_q  <= idx_q + 1'b1;
            ovf_q  <= ovf_q | lane_ovf;
            done_q <= last;
        end else if (clear) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            for (int i = 0; i < NUM_LANE; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
            end
            acc_q <= '0;
        end else begin
            if (busy && op_q == OP_DOT) acc_q <= res;
            if (busy && op_q != OP_DOT) z_q[idx_q] <= res;
            // APB writes to data registers can only land while idle
            if (wr && is_acc) acc_q <= rpwdata;
            if (wr && is_x) x_q[lane] <= rpwdata;
            if (wr && is_y) y_q[lane] <= rpwdata;
            if (wr && is_z) z_q[lane] <= rpwdata;
        end
    end
endmodule

// File: tb/tb_apb_vector_alu.sv
// tb_apb_vector_alu: table-driven register-map vectors plus scoreboarded vector-op sequences
module tb_apb_vector_alu;
    localparam int NL = 8;
    logic        clk = 1'b0;
    logic        rstp = 1'b1;
    logic        rpsel = 1'b0;
    logic        rpenable = 1'b0;
    logic [11:0] rpaddr = '0;
    logic        rpwrite = 1'b0;
    logic [31:0] rpwdata = '0;
    logic [31:0] rprdata;
    logic        rpready;
    logic        rpslverr;
    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        bit          is_read;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;
    vec_t tbl[20];

    always #5 clk = ~clk;

    apb_vector_alu #(.BW_ADDR(12), .BW_DATA(32), .NUM_LANE(NL)) dut (
        .clk      (clk),
        .rstp     (rstp),
        .rpsel    (rpsel),
        .rpenable (rpenable),
        .rpaddr   (rpaddr),
        .rpwrite  (rpwrite),
        .rpwdata  (rpwdata),
        .rprdata  (rprdata),
        .rpready  (rpready),
        .rpslverr (rpslverr)
    );

    function automatic logic [11:0] xa(int i); return 12'h100 + 12'(4 * i); endfunction
    function automatic logic [11:0] ya(int i); return 12'h200 + 12'(4 * i); endfunction
    function automatic logic [11:0] za(int i); return 12'h300 + 12'(4 * i); endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [11:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int waits);
        @(negedge clk);
        rpsel = 1'b1; rpenable = 1'b0; rpwrite = w; rpaddr = addr; rpwdata = wd;
        @(negedge clk);
        rpenable = 1'b1;
        waits = 0;
        #1;
        while (!rpready && waits < 100) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!rpready) begin
            checks++;
            failures++;
            $display("FAIL timeout addr 0x%03h: rpready still 0 after %0d cycles, required 1", addr, waits);
        end
        rd = rprdata;
        er = rpslverr;
        @(posedge clk);
        #1 rpsel = 1'b0; rpenable = 1'b0;
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp,
                      input logic exp_err = 1'b0, input int exp_waits = -1);
        logic [31:0] d;
        logic        e;
        int          w;
        exp_t        x;
        sb.push_back('{name, exp, exp_err, 1'b1});
        xfer(1'b0, addr, '0, d, e, w);
        x = sb.pop_front();
        check(x.name, d, x.data);
        check({x.name, " slverr"}, {31'b0, e}, {31'b0, x.err});
        if (exp_waits >= 0) check({x.name, " waits"}, w, exp_waits);
    endtask

    task automatic wr(input string name, input logic [11:0] addr, input logic [31:0] data,
                      input logic exp_err = 1'b0);
        logic [31:0] d;
        logic        e;
        int          w;
        exp_t        x;
        sb.push_back('{name, '0, exp_err, 1'b0});
        xfer(1'b1, addr, data, d, e, w);
        x = sb.pop_front();
        check({x.name, " slverr"}, {31'b0, e}, {31'b0, x.err});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{1'b0, 12'h004, 32'h0,        32'h0,        1'b0},
            '{1'b0, 12'h008, 32'h0,        32'h0,        1'b0},
            '{1'b0, 12'h0FC, 32'h0,        32'h0,        1'b1},
            '{1'b0, 12'h102, 32'h0,        32'h0,        1'b1},
            '{1'b0, 12'h120, 32'h0,        32'h0,        1'b1},
            '{1'b1, 12'h100, 32'h12345678, 32'h0,        1'b0},
            '{1'b0, 12'h100, 32'h0,        32'h12345678, 1'b0},
            '{1'b1, 12'h21C, 32'hA5A5A5A5, 32'h0,        1'b0},
            '{1'b0, 12'h21C, 32'h0,        32'hA5A5A5A5, 1'b0},
            '{1'b1, 12'h308, 32'h0000DEAD, 32'h0,        1'b0},
            '{1'b0, 12'h308, 32'h0,        32'h0000DEAD, 1'b0},
            '{1'b0, 12'h000, 32'h0,        32'h0,        1'b0},
            '{1'b1, 12'h004, 32'hFFFFFFFF, 32'h0,        1'b0},
            '{1'b0, 12'h004, 32'h0,        32'h0,        1'b0},
            '{1'b1, 12'h008, 32'h7,        32'h0,        1'b0},
            '{1'b0, 12'h008, 32'h0,        32'h7,        1'b0},
            '{1'b1, 12'h120, 32'hBAD,      32'h0,        1'b1},
            '{1'b0, 12'h100, 32'h0,        32'h12345678, 1'b0},
            '{1'b1, 12'h400, 32'h1,        32'h0,        1'b1},
            '{1'b0, 12'h3FC, 32'h0,        32'h0,        1'b1}
        };
        repeat (2) @(posedge clk);
        #1 rstp = 1'b0;
        #1;
        check("reset rpready", {31'b0, rpready}, 32'h1);
        check("reset rprdata", rprdata, 32'h0);

        for (int i = 0; i < 20; i++) begin
            if (tbl[i].wr) wr($sformatf("tbl[%0d] wr", i), tbl[i].addr, tbl[i].wdata, tbl[i].exp_err);
            else rd($sformatf("tbl[%0d] rd", i), tbl[i].addr, tbl[i].exp_data, tbl[i].exp_err);
        end

        for (int i = 0; i < NL; i++) begin
            wr($sformatf("add X[%0d]", i), xa(i), 32'(i + 1));
            wr($sformatf("add Y[%0d]", i), ya(i), 32'd10);
        end
        wr("add start", 12'h000, 32'h4);
        rd("add stalled Z[3]", za(3), 32'd14, 1'b0, 7);
        rd("add status", 12'h004, 32'h2);
        for (int i = 0; i < NL; i++) rd($sformatf("add Z[%0d]", i), za(i), 32'(i + 11));

        for (int i = 0; i < NL; i++) wr($sformatf("busy Y[%0d]", i), ya(i), 32'd20);
        wr("busy start", 12'h000, 32'h4);
        wr("busy restart", 12'h000, 32'h5, 1'b1);
        wr("busy clear", 12'h000, 32'h8, 1'b0);
        rd("busy Z[0]", za(0), 32'd21);
        rd("busy status", 12'h004, 32'h2);
        rd("busy Z[7]", za(7), 32'd28);

        for (int i = 0; i < NL; i++) begin
            wr($sformatf("sub X[%0d]", i), xa(i), 32'h0);
            wr($sformatf("sub Y[%0d]", i), ya(i), i == 0 ? 32'h1 : 32'h0);
        end
        wr("sub start", 12'h000, 32'h5);
        rd("sub Z[0]", za(0), 32'hFFFFFFFF);
        rd("sub Z[1]", za(1), 32'h0);
        rd("sub status", 12'h004, 32'h6);
        wr("sub clear", 12'h000, 32'h8);
        rd("sub status cleared", 12'h004, 32'h0);

        wr("dot ACC", 12'h008, 32'd5);
        for (int i = 0; i < NL; i++) begin
            wr($sformatf("dot X[%0d]", i), xa(i), 32'd2);
            wr($sformatf("dot Y[%0d]", i), ya(i), 32'd3);
        end
        wr("dot Z[5]", za(5), 32'h55);
        wr("dot start", 12'h000, 32'h7);
        rd("dot ACC", 12'h008, 32'd53);
        rd("dot status", 12'h004, 32'h2);
        rd("dot Z[5]", za(5), 32'h55);
        rd("dot Z[0]", za(0), 32'hFFFFFFFF);
        wr("dotovf ACC", 12'h008, 32'hFFFFFFF0);
        wr("dotovf start", 12'h000, 32'h7);
        rd("dotovf ACC", 12'h008, 32'h20);
        rd("dotovf status", 12'h004, 32'h6);

        wr("clr+start", 12'h000, 32'hC);
        rd("clr+start status", 12'h004, 32'h1);
        rd("clr+start Z[0]", za(0), 32'd5);
        rd("clr+start done", 12'h004, 32'h2);

        wr("mul X[0]", xa(0), 32'h10000);
        wr("mul Y[0]", ya(0), 32'h10000);
        wr("mul X[1]", xa(1), 32'd3);
        wr("mul Y[1]", ya(1), 32'd7);
        wr("mul start", 12'h000, 32'h6);
        rd("mul Z[0]", za(0), 32'h0);
        rd("mul Z[1]", za(1), 32'd21);
        rd("mul Z[2]", za(2), 32'd6);
        rd("mul status", 12'h004, 32'h6);

        wr("carry clear", 12'h000, 32'h8);
        wr("carry X[7]", xa(7), 32'hFFFFFFFF);
        wr("carry Y[7]", ya(7), 32'h1);
        wr("carry start", 12'h000, 32'h4);
        rd("carry Z[7]", za(7), 32'h0);
        rd("carry status", 12'h004, 32'h6);
        rd("carry Z[6]", za(6), 32'd5);

        wr("rst start", 12'h000, 32'h4);
        fork
            rd("rst stalled Z[1]", za(1), 32'h0, 1'b0, 2);
            begin
                repeat (3) @(posedge clk);
                #1 rstp = 1'b1;
                repeat (2) @(posedge clk);
                #1 rstp = 1'b0;
            end
        join
        rd("rst status", 12'h004, 32'h0, 1'b0, 0);
        rd("rst ACC", 12'h008, 32'h0, 1'b0, 0);
        rd("rst X[1]", xa(1), 32'h0);
        rd("rst Y[7]", ya(7), 32'h0);
        rd("rst Z[6]", za(6), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_vector_alu.md
Name: apb_vector_alu

Overview:
- APB slave compute block: banks of NUM_LANE operand registers X[i], Y[i] and result registers Z[i], plus an accumulator ACC.
- A command written to CTRL starts a sequential operation that processes one lane per clock: ADD, SUB, MUL, or DOT (multiply-accumulate into ACC).
- The block stretches the APB transfer (rpready low) on data-register accesses while busy, and reports status and errors.
- It sits on the peripheral APB bus alongside the other user IPs.

Parameters:
- BW_ADDR, 12, APB address width; only bits [BW_ADDR-1:0] are decoded. Must be >=12.
- BW_DATA, 32, data width of APB, operands, results and ACC.
- NUM_LANE, 8, number of lanes; range 1..64.
- BW_LANE_IDX, clog2(NUM_LANE) with a minimum of 1, width of the lane counter (local).

Ports:
- clk  in  1  clock
- rstp  in  1  asynchronous active-high reset
- rpsel  in  1  APB select
- rpenable  in  1  APB enable (access phase)
- rpaddr  in  BW_ADDR  byte address
- rpwrite  in  1  1=write, 0=read
- rpwdata  in  BW_DATA  write data
- rprdata  out  BW_DATA  read data; combinational, 0 when not a valid read access
- rpready  out  1  transfer complete
- rpslverr  out  1  error, valid when rpsel & rpenable & rpready

Behaviour:
- Reset is fixed: one clock (clk); reset is asynchronous and active-high (rstp).
- On reset: all X, Y, Z and ACC = 0; FSM = IDLE; busy = done = ovf = 0; rprdata = 0; rpready = 1; rpslverr = 0.
- Address map (byte offsets, word aligned; unaligned addresses are invalid):
  - 0x000 CTRL, write-only. Bits [1:0] op: 0=ADD, 1=SUB, 2=MUL, 3=DOT. Bit 2 = start. Bit 3 = clear_done (clears done and ovf). Reads return 0.
  - 0x004 STATUS, read-only. Bit 0 = busy, bit 1 = done, bit 2 = ovf. Writes are ignored with no error.
  - 0x008 ACC, read/write.
  - 0x100+4i X[i], 0x200+4i Y[i], 0x300+4i Z[i] for i < NUM_LANE; Z is read/write.
  - Any other offset is invalid.
- Access: an access occurs when rpsel=1 and rpenable=1. Register update happens on the clk edge where access & rpready & rpwrite.
- Invalid access: rpready=1, rpslverr=1, no state change, rprdata=0.
- FSM states and transitions:
  - IDLE -> RUN on a CTRL write with start=1. Latch op; lane index = 0; busy=1; done=0; ovf=0. If op=DOT, ACC is not cleared; software preloads ACC.
  - RUN: each cycle processes lane idx.
    - ADD: Z = X+Y; ovf |= carry out.
    - SUB: Z = X-Y; ovf |= borrow.
    - MUL: Z = low BW_DATA bits of X*Y; ovf |= any nonzero high half.
    - DOT: ACC = ACC + low(X*Y); ovf |= carry out of the addition. Z is untouched.
    - idx increments each cycle; at idx = NUM_LANE-1 go to IDLE with busy=0, done=1.
  - Latency: start write accepted at edge T; busy high from T+1; done=1 and busy=0 after edge T+NUM_LANE.
- Busy interactions:
  - Access to X, Y, Z or ACC while busy: rpready=0 until busy=0. The access then completes with normal semantics (reads return the final results).
  - STATUS and CTRL accesses never stall.
  - CTRL write with start=1 while busy: rpslverr=1, command ignored.
  - CTRL write with clear_done=1 while busy: allowed, no effect on done.
- Simultaneous events:
  - clear_done and start in the same write: start wins (done=0, ovf=0, busy=1).
  - Start with an invalid op is impossible, since the 2-bit op field is fully decoded.
- Wrap-around: all arithmetic is modulo 2^BW_DATA; ovf is sticky until the next start or clear_done.
- Reset asserted mid-RUN: immediate abort to the reset state; a stalled APB transfer sees rpready=1 after reset.

Decomposition:
- Package apb_vector_alu_pkg: op codes (OP_ADD/SUB/MUL/DOT), register offsets (CTRL, STATUS, ACC, X_BASE, Y_BASE, Z_BASE), CTRL/STATUS bit positions, and FSM state encodings (IDLE, RUN).
- Sub-module vector_alu_lane_unit: combinational. Inputs op, x, y, acc. Outputs result and overflow flag. Instantiated once and shared across lanes by the sequencer.

Test Plan:
- Reset, then read STATUS and ACC -> 0x0 and 0x0; read 0x0FC (invalid) -> rpslverr=1, rprdata=0.
- NUM_LANE=8: X[i]=i+1, Y[i]=10; write CTRL=0x4 (ADD, start) -> busy for exactly 8 cycles; STATUS=0x2; Z[i]=i+11.
- SUB with X[0]=0, Y[0]=1, others zero -> Z[0]=0xFFFFFFFF, STATUS=0x6 (done, ovf); CTRL=0x8 -> STATUS=0x0.
- ACC=5, X[i]=2, Y[i]=3, CTRL=0x7 (DOT) -> ACC=53, Z unchanged, ovf=0; MUL with X[0]=Y[0]=0x10000 -> Z[0]=0, ovf=1.
- Read Z[3] one cycle after start of ADD -> rpready low for 7 cycles, then final Z[3] returned; a start write during busy -> rpslverr=1 and the running op unaffected.
- Assert rstp at cycle 3 of RUN while a Z read is stalled -> all registers 0, busy=0, rpready=1 on the next access.
